// File: rtl/add16u_mon_pkg.sv
// Shared types, widths and saturating-add helper for the add16u error monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add16u_mon_pkg;

   localparam int OPW  = 16;   // operand width
   localparam int RESW = 17;   // adder result width
   localparam int ERRW = 18;   // signed error width
   localparam int SQEW = 34;   // squared error width
   localparam int ACCW = 64;   // widest counter/accumulator sat_add can serve

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

   typedef struct packed {
      logic            ovf;
      logic [ACCW-1:0] sum;
   } sat_res_t;

   // Add inc to acc, clamping at max; ovf flags that the clamp was applied.
   function automatic sat_res_t sat_add(input logic [ACCW-1:0] acc,
                                        input logic [ACCW-1:0] inc,
                                        input logic [ACCW-1:0] max);
      logic [ACCW:0] full;
      sat_res_t      r;
      full = {1'b0, acc} + {1'b0, inc};
      if (full > {1'b0, max}) begin
         r.ovf = 1'b1;
         r.sum = max;
      end else begin
         r.ovf = 1'b0;
         r.sum = full[ACCW-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/add16u_err_calc.sv
// Error datapath: S1 exact sum and signed error, S2 magnitude, square and nonzero flag.
// Latency: 2 cycles from vld_i to s2_vld_o.
// Backpressure: none; accepts one sample per cycle, flush_i drops everything in flight.
module add16u_err_calc
   import add16u_mon_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             flush_i,
   input  logic             vld_i,
   input  logic [OPW-1:0]   a_i,
   input  logic [OPW-1:0]   b_i,
   input  logic [RESW-1:0]  o_i,
   output logic             s1_vld_o,
   output logic             s2_vld_o,
   output logic [RESW-1:0]  abs_o,
   output logic [SQEW-1:0]  sq_o,
   output logic             nz_o,
   output logic [OPW-1:0]   a_o,
   output logic [OPW-1:0]   b_o
);

   logic [RESW-1:0]        exact_d;
   logic signed [ERRW-1:0] err_d;
   logic signed [ERRW-1:0] err_q;
   logic [OPW-1:0]         a1_q, b1_q;
   logic                   s1_vld_q;

   logic [RESW-1:0]        abs_d;
   logic [SQEW-1:0]        sq_d;
   logic                   nz_d;
   logic [RESW-1:0]        abs_q;
   logic [SQEW-1:0]        sq_q;
   logic                   nz_q;
   logic [OPW-1:0]         a2_q, b2_q;
   logic                   s2_vld_q;

   // The exact sum only feeds the error, so it is folded into the S1 error register.
   assign exact_d = {1'b0, a_i} + {1'b0, b_i};
   assign err_d   = $signed({1'b0, o_i}) - $signed({1'b0, exact_d});

   // |e| never exceeds 0x1FFFF, so negating the low 17 bits is exact for either sign.
   assign abs_d = err_q[ERRW-1] ? (~err_q[RESW-1:0] + 1'b1) : err_q[RESW-1:0];
   assign sq_d  = SQEW'(abs_d) * SQEW'(abs_d);
   assign nz_d  = |err_q;

   // S1: capture signed error and operands of the accepted sample.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || flush_i) s1_vld_q <= 1'b0;
      else                     s1_vld_q <= vld_i;
      if (vld_i) begin
         err_q <= err_d;
         a1_q  <= a_i;
         b1_q  <= b_i;
      end
   end

   // S2: capture magnitude, square and nonzero flag.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || flush_i) s2_vld_q <= 1'b0;
      else                     s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
         abs_q <= abs_d;
         sq_q  <= sq_d;
         nz_q  <= nz_d;
         a2_q  <= a1_q;
         b2_q  <= b1_q;
      end
   end

   assign s1_vld_o = s1_vld_q;
   assign s2_vld_o = s2_vld_q;
   assign abs_o    = abs_q;
   assign sq_o     = sq_q;
   assign nz_o     = nz_q;
   assign a_o      = a2_q;
   assign b_o      = b2_q;

endmodule

// File: rtl/add16u_err_monitor.sv
// Error statistics for a 16-bit approximate adder: counts, |e| and e^2 sums, worst case.
// Latency: sample accepted at edge t is reflected in the outputs after edge t+3.
// Backpressure: in_ready drops during clear, reset, and once a nonzero WINDOW is filled.
module add16u_err_monitor
   import add16u_mon_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int SUM_W  = 48,
   parameter int SQ_W   = 64,
   parameter int WINDOW = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPW-1:0]    in_a,
   input  logic [OPW-1:0]    in_b,
   input  logic [RESW-1:0]   in_o,
   output logic [CNT_W-1:0]  sample_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [SUM_W-1:0]  abs_sum,
   output logic [SQ_W-1:0]   sq_sum,
   output logic [RESW-1:0]   wce,
   output logic [OPW-1:0]    wce_a,
   output logic [OPW-1:0]    wce_b,
   output logic              sat,
   output logic              done
);

   localparam logic [ACCW-1:0] CNT_MAX = ACCW'({CNT_W{1'b1}});
   localparam logic [ACCW-1:0] SUM_MAX = ACCW'({SUM_W{1'b1}});
   localparam logic [ACCW-1:0] SQ_MAX  = ACCW'({SQ_W{1'b1}});

   state_e           state_q;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic             done_q;
   logic             accept;
   logic             pipe_empty_d;

   logic             s1_vld, s2_vld;
   logic [RESW-1:0]  s2_abs;
   logic [SQEW-1:0]  s2_sq;
   logic             s2_nz;
   logic [OPW-1:0]   s2_a, s2_b;

   logic             s3_vld_q;
   logic [RESW-1:0]  s3_abs_q;
   logic [SQEW-1:0]  s3_sq_q;
   logic             s3_nz_q;
   logic [OPW-1:0]   s3_a_q, s3_b_q;

   logic [CNT_W-1:0] sample_cnt_q, err_cnt_q;
   logic [SUM_W-1:0] abs_sum_q;
   logic [SQ_W-1:0]  sq_sum_q;
   logic [RESW-1:0]  wce_q;
   logic [OPW-1:0]   wce_a_q, wce_b_q;
   logic             sat_q;

   sat_res_t         sc_d, ec_d, as_d, ss_d;
   logic             unused_hi_bits;

   // Clear blocks the handshake in its own cycle so nothing slips past the flush.
   assign in_ready  = rst_n && !clear && (state_q == RUN);
   assign accept    = in_valid && in_ready;
   assign acc_cnt_d = acc_cnt_q + 1'b1;
   // True when S1..S3 will all be empty after this edge; the last commit lands on it too.
   assign pipe_empty_d = !accept && !s1_vld && !s2_vld;

   add16u_err_calc u_calc (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .flush_i  (clear),
      .vld_i    (accept),
      .a_i      (in_a),
      .b_i      (in_b),
      .o_i      (in_o),
      .s1_vld_o (s1_vld),
      .s2_vld_o (s2_vld),
      .abs_o    (s2_abs),
      .sq_o     (s2_sq),
      .nz_o     (s2_nz),
      .a_o      (s2_a),
      .b_o      (s2_b)
   );

   // Window FSM: counts accepts, stops intake at WINDOW, flags done once drained.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state_q   <= RUN;
         acc_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (accept) begin
                  acc_cnt_q <= acc_cnt_d;
                  if ((WINDOW != 0) && (acc_cnt_d == CNT_W'(WINDOW))) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (pipe_empty_d) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE:    state_q <= DONE;
            default: state_q <= RUN;
         endcase
      end
   end

   // S3: retime the S2 results ahead of the accumulator adders.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) s3_vld_q <= 1'b0;
      else                 s3_vld_q <= s2_vld;
      if (s2_vld) begin
         s3_abs_q <= s2_abs;
         s3_sq_q  <= s2_sq;
         s3_nz_q  <= s2_nz;
         s3_a_q   <= s2_a;
         s3_b_q   <= s2_b;
      end
   end

   // Saturating next values for every counter and accumulator.
   always_comb begin
      sc_d = sat_add(ACCW'(sample_cnt_q), ACCW'(1),        CNT_MAX);
      ec_d = sat_add(ACCW'(err_cnt_q),    ACCW'(s3_nz_q),  CNT_MAX);
      as_d = sat_add(ACCW'(abs_sum_q),    ACCW'(s3_abs_q), SUM_MAX);
      ss_d = sat_add(ACCW'(sq_sum_q),     ACCW'(s3_sq_q),  SQ_MAX);
   end

   // Upper result bits are idle when an accumulator is narrower than the helper.
   assign unused_hi_bits = ^{sc_d.sum, ec_d.sum, as_d.sum, ss_d.sum};

   // Commit S3 into the statistics; clear wins over a same-cycle commit.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         sample_cnt_q <= '0;
         err_cnt_q    <= '0;
         abs_sum_q    <= '0;
         sq_sum_q     <= '0;
         wce_q        <= '0;
         wce_a_q      <= '0;
         wce_b_q      <= '0;
         sat_q        <= 1'b0;
      end else if (s3_vld_q) begin
         sample_cnt_q <= sc_d.sum[CNT_W-1:0];
         err_cnt_q    <= ec_d.sum[CNT_W-1:0];
         abs_sum_q    <= as_d.sum[SUM_W-1:0];
         sq_sum_q     <= ss_d.sum[SQ_W-1:0];
         sat_q        <= sat_q | sc_d.ovf | ec_d.ovf | as_d.ovf | ss_d.ovf;
         // Strict compare keeps the operands of the first sample to hit the maximum.
         if (s3_abs_q > wce_q) begin
            wce_q   <= s3_abs_q;
            wce_a_q <= s3_a_q;
            wce_b_q <= s3_b_q;
         end
      end
   end

   assign sample_cnt = sample_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign abs_sum    = abs_sum_q;
   assign sq_sum     = sq_sum_q;
   assign wce        = wce_q;
   assign wce_a      = wce_a_q;
   assign wce_b      = wce_b_q;
   assign sat        = sat_q;
   assign done       = done_q;

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Directed bench for add16u_err_monitor with a commit-ordered expected-state queue.
// Latency: checks every cycle; expected state advances three edges after each accept.
// Backpressure: handshakes are observed from in_ready before each edge.
module tb_add16u_err_monitor;

   localparam int CNT_W  = 32;
   localparam int SUM_W  = 8;
   localparam int SQ_W   = 64;
   localparam int WINDOW = 4;

   logic              clk;
   logic              rst_n;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       in_a;
   logic [15:0]       in_b;
   logic [16:0]       in_o;
   logic [CNT_W-1:0]  sample_cnt;
   logic [CNT_W-1:0]  err_cnt;
   logic [SUM_W-1:0]  abs_sum;
   logic [SQ_W-1:0]   sq_sum;
   logic [16:0]       wce;
   logic [15:0]       wce_a;
   logic [15:0]       wce_b;
   logic              sat;
   logic              done;

   add16u_err_monitor #(
      .CNT_W (CNT_W),
      .SUM_W (SUM_W),
      .SQ_W  (SQ_W),
      .WINDOW(WINDOW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_o      (in_o),
      .sample_cnt(sample_cnt),
      .err_cnt   (err_cnt),
      .abs_sum   (abs_sum),
      .sq_sum    (sq_sum),
      .wce       (wce),
      .wce_a     (wce_a),
      .wce_b     (wce_b),
      .sat       (sat),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [64:0] sc, ec, as, ss;
      logic [16:0] w;
      logic [15:0] wa, wb;
      logic        sat;
   } exp_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        sb_q[$];
   exp_t        cur;
   bit [2:0]    due;
   logic [64:0] m_sc, m_ec, m_as, m_ss;
   logic [16:0] m_w;
   logic [15:0] m_wa, m_wb;
   bit          m_sat;

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sc = '0; m_ec = '0; m_as = '0; m_ss = '0;
      m_w = '0; m_wa = '0; m_wb = '0; m_sat = 1'b0;
      sb_q.delete();
      due = '0;
      cur.sc = '0; cur.ec = '0; cur.as = '0; cur.ss = '0;
      cur.w = '0; cur.wa = '0; cur.wb = '0; cur.sat = 1'b0;
   endtask

   task automatic madd(inout logic [64:0] acc, input logic [64:0] inc, input int w);
      logic [64:0] mx;
      mx = (65'd1 << w) - 65'd1;
      if (acc + inc > mx) begin
         acc   = mx;
         m_sat = 1'b1;
      end else begin
         acc = acc + inc;
      end
   endtask

   // Fold the sample on the inputs into the model and queue the resulting state.
   task automatic model_accept();
      int          e;
      logic [16:0] ab;
      logic [64:0] sq;
      exp_t        x;
      e  = int'(in_o) - int'(in_a) - int'(in_b);
      ab = 17'((e < 0) ? -e : e);
      sq = 65'(ab) * 65'(ab);
      madd(m_sc, 65'd1, CNT_W);
      madd(m_ec, (e != 0) ? 65'd1 : 65'd0, CNT_W);
      madd(m_as, 65'(ab), SUM_W);
      madd(m_ss, sq, SQ_W);
      if (ab > m_w) begin
         m_w = ab; m_wa = in_a; m_wb = in_b;
      end
      x.sc = m_sc; x.ec = m_ec; x.as = m_as; x.ss = m_ss;
      x.w = m_w; x.wa = m_wa; x.wb = m_wb; x.sat = m_sat;
      sb_q.push_back(x);
   endtask

   // One clock: note the handshake, step the edge, then check all statistics.
   task automatic tick(output bit acc);
      bit clr, rst;
      @(negedge clk);
      rst = (rst_n !== 1'b1);
      clr = (clear === 1'b1);
      acc = (in_valid === 1'b1) && (in_ready === 1'b1);
      if (acc && !rst && !clr) model_accept();
      @(posedge clk);
      #1;
      if (rst || clr) begin
         model_reset();
      end else begin
         if (due[2] && sb_q.size() != 0) cur = sb_q.pop_front();
         due = {due[1:0], acc};
      end
      chk("sample_cnt", 65'(sample_cnt), cur.sc);
      chk("err_cnt",    65'(err_cnt),    cur.ec);
      chk("abs_sum",    65'(abs_sum),    cur.as);
      chk("sq_sum",     65'(sq_sum),     cur.ss);
      chk("wce",        65'(wce),        65'(cur.w));
      chk("wce_a",      65'(wce_a),      65'(cur.wa));
      chk("wce_b",      65'(wce_b),      65'(cur.wb));
      chk("sat",        65'(sat),        65'(cur.sat));
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [16:0] o);
      bit acc;
      in_a = a; in_b = b; in_o = o; in_valid = 1'b1;
      tick(acc);
      chk("handshake", 65'(acc), 65'd1);
   endtask

   task automatic idle(input int n);
      bit acc;
      in_valid = 1'b0;
      for (int k = 0; k < n; k++) tick(acc);
   endtask

   task automatic do_clear();
      bit acc;
      clear = 1'b1;
      #1;
      chk("clear_ready_low", 65'(in_ready), 65'd0);
      tick(acc);
      chk("clear_no_handshake", 65'(acc), 65'd0);
      clear = 1'b0;
      #1;
      chk("clear_ready_high", 65'(in_ready), 65'd1);
      chk("clear_done_low", 65'(done), 65'd0);
   endtask

   initial begin
      bit acc;
      int n_acc, last_acc, first_done;

      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1;
      in_a = 16'hAAAA; in_b = 16'h5555; in_o = 17'h00001;
      model_reset();

      // Reset held two cycles with valid high
      tick(acc);
      chk("rst_ready", 65'(in_ready), 65'd0);
      chk("rst_done", 65'(done), 65'd0);
      tick(acc);
      chk("rst_ready2", 65'(in_ready), 65'd0);
      chk("rst_no_handshake", 65'(acc), 65'd0);
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      chk("post_rst_ready", 65'(in_ready), 65'd1);
      chk("post_rst_done", 65'(done), 65'd0);

      // Single error sample: e = 0xFF - 8 = 247
      drive(16'h0003, 16'h0005, 17'h000FF);
      idle(2);
      chk("latency_not_yet", 65'(sample_cnt), 65'd0);
      idle(1);
      chk("single_cnt", 65'(sample_cnt), 65'd1);
      chk("single_err", 65'(err_cnt), 65'd1);
      chk("single_abs", 65'(abs_sum), 65'd247);
      chk("single_sq", 65'(sq_sum), 65'd61009);
      chk("single_wce", 65'(wce), 65'd247);
      chk("single_wce_a", 65'(wce_a), 65'h3);
      chk("single_wce_b", 65'(wce_b), 65'h5);
      do_clear();

      // Exact sample then e = -14, back to back
      drive(16'h1234, 16'h4321, 17'h05555);
      drive(16'hFFFF, 16'hFFFF, 17'h1FFF0);
      idle(3);
      chk("neg_cnt", 65'(sample_cnt), 65'd2);
      chk("neg_err", 65'(err_cnt), 65'd1);
      chk("neg_abs", 65'(abs_sum), 65'd14);
      chk("neg_sq", 65'(sq_sum), 65'd196);
      chk("neg_wce", 65'(wce), 65'd14);
      chk("neg_wce_a", 65'(wce_a), 65'hFFFF);
      do_clear();

      // Window of 4 with valid held high
      n_acc = 0; last_acc = -1; first_done = -1;
      for (int i = 0; i < 10; i++) begin
         in_a = 16'(i * 257);
         in_b = 16'(i * 3);
         in_o = 17'(in_a) + 17'(in_b) + 17'(i % 3);
         in_valid = 1'b1;
         tick(acc);
         if (acc) begin
            n_acc++;
            last_acc = i;
         end
         if (done === 1'b1 && first_done < 0) first_done = i;
      end
      chk("win_handshakes", 65'(n_acc), 65'd4);
      chk("win_ready_low", 65'(in_ready), 65'd0);
      chk("win_done_latency", 65'(first_done - last_acc), 65'd3);
      chk("win_done", 65'(done), 65'd1);
      chk("win_cnt", 65'(sample_cnt), 65'd4);
      chk("win_err", 65'(err_cnt), 65'd2);
      idle(1);
      do_clear();

      // Tie at |e| = 79: first occurrence keeps wce operands
      drive(16'h0001, 16'h0002, 17'd82);
      drive(16'h0010, 16'h0020, 17'd127);
      idle(3);
      chk("tie_wce", 65'(wce), 65'd79);
      chk("tie_wce_a", 65'(wce_a), 65'h1);
      chk("tie_wce_b", 65'(wce_b), 65'h2);
      chk("tie_abs", 65'(abs_sum), 65'd158);
      // Third sample is flushed by a clear in the following cycle
      drive(16'h0005, 16'h0005, 17'd100);
      in_valid = 1'b0;
      do_clear();
      idle(4);
      chk("flush_cnt", 65'(sample_cnt), 65'd0);
      chk("flush_wce", 65'(wce), 65'd0);

      // Saturation of the 8-bit |e| accumulator
      for (int i = 1; i <= 4; i++)
         drive(16'(i), 16'(i), 17'(2 * i + 79));
      idle(3);
      chk("sat_abs", 65'(abs_sum), 65'd255);
      chk("sat_flag", 65'(sat), 65'd1);
      chk("sat_sq", 65'(sq_sum), 65'd24964);
      chk("sat_cnt", 65'(sample_cnt), 65'd4);
      idle(3);
      chk("sat_sticky", 65'(sat), 65'd1);
      chk("sat_done", 65'(done), 65'd1);
      do_clear();
      idle(1);
      chk("sat_cleared", 65'(sat), 65'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/add16u_err_monitor.md
Name: add16u_err_monitor

Overview:
- Streaming error-characterisation stage directly downstream of a 16-bit unsigned approximate adder (17-bit result).
- Each sample carries the operand pair and the approximate result. The block recomputes the exact sum and accumulates the error statistics used to grade the component on FPGA: sample count, error count (EP), sum of |e| (MAE), sum of e^2 (MSE), and worst-case error (WCE) with its operands.
- An optional measurement window stops intake after N samples and flags completion.

Parameters:
- CNT_W, 32, width of the sample and error counters.
- SUM_W, 48, width of the |e| accumulator.
- SQ_W, 64, width of the e^2 accumulator.
- WINDOW, 0, number of samples per measurement; 0 means unlimited (done never asserts).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- clear  in  1  synchronous stats clear / restart window
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_a  in  16  operand A
- in_b  in  16  operand B
- in_o  in  17  approximate adder result under test
- sample_cnt  out  CNT_W  accepted samples whose stats are committed
- err_cnt  out  CNT_W  samples with e != 0
- abs_sum  out  SUM_W  sum of |e|
- sq_sum  out  SQ_W  sum of e^2
- wce  out  17  max |e| seen
- wce_a  out  16  in_a of the first sample reaching wce
- wce_b  out  16  in_b of the first sample reaching wce
- sat  out  1  sticky: some counter or accumulator saturated
- done  out  1  window complete and pipeline drained

Behaviour:
- Reset (rst_n=0 at an edge): all outputs 0; pipeline valids 0; FSM goes to RUN. in_ready is 0 during the reset cycle and 1 from the next cycle.
- Arithmetic:
  - exact = in_a + in_b (17 bits).
  - e = in_o - exact, signed 18 bits.
  - |e| is 17 bits; e^2 is 34 bits, unsigned.
- Pipeline:
  - S1 registers exact, e and the operands.
  - S2 registers |e|, e^2 and the nonzero flag.
  - S3 updates the accumulators.
  - A sample accepted at edge t is reflected in the outputs after edge t+3.
  - No backpressure inside the pipe; throughput is 1 sample/cycle.
- Accumulation:
  - sample_cnt +1 per sample.
  - err_cnt +1 if e != 0.
  - abs_sum += |e|; sq_sum += e^2.
  - Every counter/accumulator saturates at all-ones and sets sat. sat stays set until clear or reset.
- WCE: update wce, wce_a and wce_b only when |e| > wce (strict), so ties keep the first occurrence. An exact-only run leaves wce=0 and wce_a=wce_b=0.
- FSM states:
  - RUN: in_ready=1. An internal accept counter increments per handshake. When WINDOW != 0 and the accept count reaches WINDOW, go to DRAIN; in_ready=0 from the cycle after the WINDOW-th accept.
  - DRAIN: in_ready=0. Wait until S1/S2/S3 valids are all 0, then go to DONE.
  - DONE: in_ready=0, done=1. Outputs hold until clear.
- clear (any state):
  - In the cycle clear=1: in_ready=0 and no handshake occurs.
  - Next edge: pipeline valids, all outputs and the accept counter go to 0; FSM goes to RUN.
  - In-flight samples are discarded.
- Simultaneous events: rst_n=0 overrides clear. clear overrides an accumulator commit in the same cycle. in_valid with in_ready=0 is ignored, and the source must hold it.
- WINDOW=0: the FSM stays in RUN forever and done never asserts.

Decomposition:
- Package add16u_mon_pkg:
  - state enum {RUN, DRAIN, DONE}
  - constants OPW=16, RESW=17, ERRW=18, SQEW=34
  - function sat_add(acc, inc) returning the saturated sum and an overflow flag.
- One sub-module, add16u_err_calc: the combinational/registered S1–S2 datapath (exact sum, signed error, abs, square).
- The top holds the FSM, the accumulators and WCE tracking.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → all outputs 0 and in_ready=0. After release: in_ready=1, done=0.
- Single error sample A=0x0003, B=0x0005, O=0x000FF → after 3 edges:
  - sample_cnt=1, err_cnt=1
  - abs_sum=247, sq_sum=61009
  - wce=247, wce_a=0x0003, wce_b=0x0005
- Exact plus negative error, back-to-back:
  - Samples: (0x1234, 0x4321, 0x05555); then (0xFFFF, 0xFFFF, 0x1FFF0) with e=-14.
  - Expect sample_cnt=2, err_cnt=1, abs_sum=14, sq_sum=196, wce=14.
- Window with WINDOW=4, in_valid held high:
  - Exactly 4 handshakes, then in_ready=0.
  - done=1 three cycles after the last accept; sample_cnt=4.
  - clear → in_ready=1 and all stats 0.
- Tie and clear mid-pipe:
  - Two samples both giving |e|=79 → wce_a/wce_b from the first.
  - Assert clear one cycle after a third accept → the third sample is never counted (sample_cnt=0 after clear).
- Saturation with SUM_W=8: four samples with |e|=79 → abs_sum=255 and sat=1. sat holds until clear.
